// File: rtl/bit_select_sequential.sv
// Sequential select unit: finds the bit position of the k-th set bit, one nibble per enabled cycle.
// Optional macro EARLY_EXIT_EN: finish on the nibble holding the k-th one instead of a fixed N cycles.
module bit_select_sequential #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clk_en_i,
    input  logic [DATA_WIDTH-1:0]         operand_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] rank_i,
    input  logic                          data_valid_i,
    output logic                          data_valid_o,
    output logic                          idle_o,
    output logic                          found_o,
    output logic [$clog2(DATA_WIDTH)-1:0] position_o
);

    localparam int unsigned PW = $clog2(DATA_WIDTH);
    localparam int unsigned RW = PW;
    localparam int unsigned N  = DATA_WIDTH / 4;
    localparam int unsigned NW = PW - 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RW-1:0]         rank_q, rank_d;
    logic [NW-1:0]         nib_q, nib_d;
    logic                  found_q, found_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  valid_q, valid_d;
`ifndef EARLY_EXIT_EN
    logic                  hit_q, hit_d;
    logic [PW-1:0]         hit_pos_q, hit_pos_d;
`endif

    logic [2:0]    nib_cnt;
    logic          nib_hit;
    logic          nib_last;
    logic [PW-1:0] nib_pos;

    function automatic logic [2:0] popcnt4(input logic [3:0] nib);
        return 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
    endfunction

    // Index (LSB first) of the r-th one inside a nibble; only meaningful when r < popcount.
    function automatic logic [1:0] sel_in_nibble(input logic [3:0] nib, input logic [1:0] r);
        logic [2:0] seen;
        logic [1:0] idx;
        seen = '0;
        idx  = '0;
        for (int i = 0; i < 4; i++) begin
            if (nib[i]) begin
                if (seen == 3'(r)) idx = 2'(i);
                seen = seen + 3'd1;
            end
        end
        return idx;
    endfunction

    assign nib_cnt  = popcnt4(data_q[3:0]);
    assign nib_hit  = RW'(nib_cnt) > rank_q;
    assign nib_last = (nib_q == NW'(N - 1));
    assign nib_pos  = PW'({nib_q, sel_in_nibble(data_q[3:0], rank_q[1:0])});

    // Next-state and result logic
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rank_d    = rank_q;
        nib_d     = nib_q;
        found_d   = found_q;
        pos_d     = pos_q;
        valid_d   = 1'b0;
`ifndef EARLY_EXIT_EN
        hit_d     = hit_q;
        hit_pos_d = hit_pos_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (data_valid_i) begin
                    state_d   = SCAN;
                    data_d    = operand_i;
                    rank_d    = rank_i;
                    nib_d     = '0;
`ifndef EARLY_EXIT_EN
                    hit_d     = 1'b0;
                    hit_pos_d = '0;
`endif
                end
            end
            SCAN: begin
                data_d = data_q >> 4;
                nib_d  = nib_q + NW'(1);
                if (!nib_hit) rank_d = rank_q - RW'(nib_cnt);
`ifdef EARLY_EXIT_EN
                if (nib_hit || nib_last) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    found_d = nib_hit;
                    pos_d   = nib_hit ? nib_pos : '0;
                end
`else
                // Keep only the first hit; later nibbles are still walked for constant latency.
                if (nib_hit && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_pos_d = nib_pos;
                end
                if (nib_last) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    found_d = hit_q || nib_hit;
                    pos_d   = hit_q ? hit_pos_q : (nib_hit ? nib_pos : '0);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            data_q    <= '0;
            rank_q    <= '0;
            nib_q     <= '0;
            found_q   <= 1'b0;
            pos_q     <= '0;
            valid_q   <= 1'b0;
`ifndef EARLY_EXIT_EN
            hit_q     <= 1'b0;
            hit_pos_q <= '0;
`endif
        end else if (clk_en_i) begin
            state_q   <= state_d;
            data_q    <= data_d;
            rank_q    <= rank_d;
            nib_q     <= nib_d;
            found_q   <= found_d;
            pos_q     <= pos_d;
            valid_q   <= valid_d;
`ifndef EARLY_EXIT_EN
            hit_q     <= hit_d;
            hit_pos_q <= hit_pos_d;
`endif
        end
    end

    assign idle_o       = (state_q == IDLE);
    assign data_valid_o = valid_q;
    assign found_o      = found_q;
    assign position_o   = pos_q;

endmodule
